// File: rtl/soft_rst_wdg_if.sv
// Register bus between the core and the watchdog / soft-reset requester.
// master: core side driving strobes, address and write data.
// slave : watchdog side returning registered read data.
interface soft_rst_wdg_if;
  logic        we_i;
  logic        re_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (
    output we_i,
    output re_i,
    output addr_i,
    output wdata_i,
    input  rdata_o
  );

  modport slave (
    input  we_i,
    input  re_i,
    input  addr_i,
    input  wdata_i,
    output rdata_o
  );
endinterface

// File: rtl/soft_rst_wdg.sv
// soft_rst_wdg: watchdog timer plus keyed software-reset requester.
// It is the only source of soft_rst_en into the system reset controller and
// it sits inside the reset domain it drives, so rst_n clears it completely.
// Optional feature macro: WDG_PRE_IRQ_EN adds the WARN register and irq_o.
// Register map (word index addr_i[4:2]):
//   0 CTRL [0]=EN [1]=LOCK, 1 LOAD, 2 KICK (wo), 3 COUNT (ro), 4 WARN.
module soft_rst_wdg #(
  parameter int          TICK_DIV = 16,
  parameter logic [31:0] KICK_KEY = 32'h5A5AA5A5,
  parameter logic [31:0] RST_KEY  = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  soft_rst_wdg_if.slave     bus,
  output logic              soft_rst_en
`ifdef WDG_PRE_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  // Prescaler needs at least one bit even when every cycle is a tick.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  localparam logic [2:0] IDX_CTRL  = 3'd0;
  localparam logic [2:0] IDX_LOAD  = 3'd1;
  localparam logic [2:0] IDX_KICK  = 3'd2;
  localparam logic [2:0] IDX_COUNT = 3'd3;
  localparam logic [2:0] IDX_WARN  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  state_t        state_r, state_n;
  logic          en_r, en_n;
  logic          lock_r, lock_n;
  logic [31:0]   load_r, load_n;
  logic [31:0]   count_r, count_n;
  logic [PW-1:0] presc_r, presc_n;
  logic [31:0]   rdata_r;
  logic          soft_rst_en_r;
`ifdef WDG_PRE_IRQ_EN
  logic [31:0]   warn_r, warn_n;
  logic          irq_r;
`endif

  logic [2:0]    addr_idx_s;
  logic          live_s;
  logic          kick_rst_s;
  logic          kick_reload_s;
  logic          ctrl_wr_ok_s;
  logic          load_wr_s;
  logic          tick_s;
  logic [31:0]   rd_val_s;
  logic          unused_s;

  // Byte offsets are word aligned; the two low address bits carry nothing.
  assign unused_s = ^bus.addr_i[1:0];

  assign addr_idx_s    = bus.addr_i[4:2];
  // Once firing, every register write is ignored until rst_n.
  assign live_s        = (state_r != ST_FIRE);
  assign kick_rst_s    = live_s && bus.we_i && (addr_idx_s == IDX_KICK) && (bus.wdata_i == RST_KEY);
  assign kick_reload_s = live_s && bus.we_i && (addr_idx_s == IDX_KICK) && (bus.wdata_i == KICK_KEY);
  assign ctrl_wr_ok_s  = live_s && bus.we_i && (addr_idx_s == IDX_CTRL) && !lock_r;
  assign load_wr_s     = live_s && bus.we_i && (addr_idx_s == IDX_LOAD);
  assign tick_s        = (presc_r == PRESC_LAST);

  // Read mux: value presented at the edge where re_i is sampled (pre-write).
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (addr_idx_s)
      IDX_CTRL:  rd_val_s = {30'h0000_0000, lock_r, en_r};
      IDX_LOAD:  rd_val_s = load_r;
      IDX_KICK:  rd_val_s = 32'h0000_0000;
      IDX_COUNT: rd_val_s = count_r;
`ifdef WDG_PRE_IRQ_EN
      IDX_WARN:  rd_val_s = warn_r;
`else
      IDX_WARN:  rd_val_s = 32'h0000_0000;
`endif
      default:   rd_val_s = 32'h0000_0000;
    endcase
  end

  // Next-state and register-update logic; RST_KEY beats KICK_KEY beats the tick.
  always_comb begin
    state_n = state_r;
    en_n    = en_r;
    lock_n  = lock_r;
    load_n  = load_r;
    count_n = count_r;
    presc_n = presc_r;
`ifdef WDG_PRE_IRQ_EN
    warn_n  = warn_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (kick_rst_s) begin
          state_n = ST_FIRE;
        end else if (kick_reload_s) begin
          count_n = load_r;
          presc_n = PRESC_ZERO;
        end else if (ctrl_wr_ok_s) begin
          lock_n = bus.wdata_i[1];
          if (bus.wdata_i[0]) begin
            en_n    = 1'b1;
            count_n = load_r;
            presc_n = PRESC_ZERO;
            state_n = ST_RUN;
          end else begin
            en_n = 1'b0;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (kick_rst_s) begin
          state_n = ST_FIRE;
        end else if (kick_reload_s) begin
          count_n = load_r;
          presc_n = PRESC_ZERO;
        end else if (ctrl_wr_ok_s && !bus.wdata_i[0]) begin
          // Disabling freezes the counter where it is.
          en_n    = 1'b0;
          lock_n  = bus.wdata_i[1];
          state_n = ST_IDLE;
        end else begin
          if (ctrl_wr_ok_s) begin
            lock_n = bus.wdata_i[1];
          end else begin
            lock_n = lock_r;
          end
          if (tick_s) begin
            presc_n = PRESC_ZERO;
            if (count_r == 32'h0000_0000) begin
              state_n = ST_FIRE;
            end else begin
              count_n = count_r - 32'h0000_0001;
            end
          end else begin
            presc_n = presc_r + PRESC_ONE;
          end
        end
      end
      ST_FIRE: begin
        state_n = ST_FIRE;
      end
      default: begin
        // An illegal encoding is treated as a timeout: request the reset.
        state_n = ST_FIRE;
      end
    endcase

    if (load_wr_s) begin
      load_n = bus.wdata_i;
    end else begin
      load_n = load_r;
    end
`ifdef WDG_PRE_IRQ_EN
    if (live_s && bus.we_i && (addr_idx_s == IDX_WARN)) begin
      warn_n = bus.wdata_i;
    end else begin
      warn_n = warn_r;
    end
`endif
  end

  // State, register file and registered outputs; rst_n returns all to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      en_r          <= 1'b0;
      lock_r        <= 1'b0;
      load_r        <= 32'h0000_0000;
      count_r       <= 32'h0000_0000;
      presc_r       <= PRESC_ZERO;
      rdata_r       <= 32'h0000_0000;
      soft_rst_en_r <= 1'b0;
`ifdef WDG_PRE_IRQ_EN
      warn_r        <= 32'h0000_0000;
      irq_r         <= 1'b0;
`endif
    end else begin
      state_r       <= state_n;
      en_r          <= en_n;
      lock_r        <= lock_n;
      load_r        <= load_n;
      count_r       <= count_n;
      presc_r       <= presc_n;
      rdata_r       <= bus.re_i ? rd_val_s : rdata_r;
      // Asserted the cycle after FIRE is entered and held until rst_n.
      soft_rst_en_r <= (state_r == ST_FIRE);
`ifdef WDG_PRE_IRQ_EN
      // Looks at the post-edge counter so a reload drops the warning at once.
      irq_r         <= (state_n == ST_RUN) && (count_n <= warn_n);
      warn_r        <= warn_n;
`endif
    end
  end

  assign bus.rdata_o = rdata_r;
  assign soft_rst_en = soft_rst_en_r;
`ifdef WDG_PRE_IRQ_EN
  assign irq_o       = irq_r;
`endif

endmodule

// File: tb/tb_soft_rst_wdg.sv
// Self-checking bench for soft_rst_wdg: directed scenarios plus randomized
// register traffic, all compared against a cycle-level behavioural model.
module tb_soft_rst_wdg;
  localparam int          TD       = 4;
  localparam logic [31:0] KICK_KEY = 32'h5A5AA5A5;
  localparam logic [31:0] RST_KEY  = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n;
  logic soft_rst_en;
`ifdef WDG_PRE_IRQ_EN
  logic irq;
`endif

  soft_rst_wdg_if bus_if();

  soft_rst_wdg #(.TICK_DIV(TD), .KICK_KEY(KICK_KEY), .RST_KEY(RST_KEY)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .soft_rst_en (soft_rst_en)
`ifdef WDG_PRE_IRQ_EN
    ,
    .irq_o       (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: watchdog described as "running / fired", a phase
  // counter within the current tick period and the visible registers.
  bit          m_running, m_fired, m_en, m_lock, m_sre, m_irq;
  logic [31:0] m_load, m_count, m_warn, m_rdata;
  int          m_phase;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    case (addr[4:2])
      3'd0: return {30'd0, m_lock, m_en};
      3'd1: return m_load;
      3'd3: return m_count;
`ifdef WDG_PRE_IRQ_EN
      3'd4: return m_warn;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit we, input bit re,
                            input logic [4:0] addr, input logic [31:0] wd);
    logic [31:0] rv;
    bit started;
    int a;
    rv = model_read(addr);
    a = int'(addr[4:2]);
    started = 1'b0;
    if (!rst) begin
      m_running = 0; m_fired = 0; m_en = 0; m_lock = 0; m_sre = 0; m_irq = 0;
      m_load = 0; m_count = 0; m_warn = 0; m_rdata = 0; m_phase = 0;
      return;
    end
    m_sre = m_fired;
    if (re) m_rdata = rv;
    if (!m_fired) begin
      if (we && a == 2 && wd == RST_KEY) begin
        m_fired = 1; m_running = 0;
      end else if (we && a == 2 && wd == KICK_KEY) begin
        m_count = m_load; m_phase = 0;
      end else begin
        if (we && a == 0 && !m_lock) begin
          if (wd[1]) m_lock = 1;
          if (!m_running && wd[0]) begin
            m_en = 1; m_running = 1; m_count = m_load; m_phase = 0; started = 1;
          end else if (m_running && !wd[0]) begin
            m_en = 0; m_running = 0;
          end
        end
        if (m_running && !started) begin
          if (m_phase == TD - 1) begin
            m_phase = 0;
            if (m_count == 0) begin m_fired = 1; m_running = 0; end
            else m_count = m_count - 1;
          end else begin
            m_phase = m_phase + 1;
          end
        end
      end
      if (we && a == 1) m_load = wd;
`ifdef WDG_PRE_IRQ_EN
      if (we && a == 4) m_warn = wd;
`endif
    end
    m_irq = m_running && (m_count <= m_warn);
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic step(input bit rst, input bit we, input bit re,
                      input logic [4:0] addr, input logic [31:0] wd);
    rst_n = rst;
    bus_if.we_i = we;
    bus_if.re_i = re;
    bus_if.addr_i = addr;
    bus_if.wdata_i = wd;
    @(posedge clk);
    model_step(rst, we, re, addr, wd);
    #1;
    check_val("rdata", bus_if.rdata_o, m_rdata);
    check_val("soft_rst_en", {31'd0, soft_rst_en}, {31'd0, m_sre});
`ifdef WDG_PRE_IRQ_EN
    check_val("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 5'h00, 32'd0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
    step(1'b1, 1'b1, 1'b0, addr, wd);
  endtask

  task automatic rd_expect(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    step(1'b1, 1'b0, 1'b1, addr, 32'd0);
    check_val(tag, bus_if.rdata_o, exp);
  endtask

  initial begin
    int k;
    logic [31:0] min_cnt;
    bit seen_fire;
    rst_n = 1'b0;
    bus_if.we_i = 1'b0; bus_if.re_i = 1'b0;
    bus_if.addr_i = 5'h00; bus_if.wdata_i = 32'd0;

    // Reset state
    do_reset();
    do_reset();
    check_val("reset_sre", {31'd0, soft_rst_en}, 32'd0);
    rd_expect("reset_ctrl", 5'h00, 32'd0);
    rd_expect("reset_count", 5'h0C, 32'd0);

    // Expiry with no kicks: 3,2,1,0 then fire 17 cycles after enable
    wr(5'h04, 32'd3);
    wr(5'h00, 32'd1);
    k = 0;
    while (soft_rst_en !== 1'b1 && k < 100) begin
      step(1'b1, 1'b0, 1'b1, 5'h0C, 32'd0);
      k++;
    end
    check_val("fire_latency", k, 32'd17);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 5'h08, KICK_KEY);
    check_val("fire_held", {31'd0, soft_rst_en}, 32'd1);
    do_reset();
    check_val("fire_cleared", {31'd0, soft_rst_en}, 32'd0);

    // Periodic kicks keep it alive
    wr(5'h04, 32'd3);
    wr(5'h00, 32'd1);
    min_cnt = 32'hFFFF_FFFF;
    seen_fire = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i % 10 == 9) wr(5'h08, KICK_KEY);
      else begin
        step(1'b1, 1'b0, 1'b1, 5'h0C, 32'd0);
        if (bus_if.rdata_o < min_cnt) min_cnt = bus_if.rdata_o;
      end
      if (soft_rst_en) seen_fire = 1'b1;
    end
    check_val("kick_no_fire", {31'd0, seen_fire}, 32'd0);
    check_val("kick_min_ge1", {31'd0, (min_cnt >= 32'd1)}, 32'd1);

    // RST_KEY from IDLE, then a bogus key
    do_reset();
    wr(5'h08, RST_KEY);
    check_val("rstkey_edge1", {31'd0, soft_rst_en}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
    check_val("rstkey_edge2", {31'd0, soft_rst_en}, 32'd1);
    do_reset();
    wr(5'h04, 32'd7);
    wr(5'h08, 32'h12345678);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
    check_val("bogus_key", {31'd0, soft_rst_en}, 32'd0);
    rd_expect("bogus_count", 5'h0C, 32'd0);

    // LOCK blocks CTRL writes; rst_n clears it
    wr(5'h04, 32'd100);
    wr(5'h00, 32'd3);
    wr(5'h00, 32'd0);
    rd_expect("lock_ctrl", 5'h00, 32'd3);
    do_reset();
    rd_expect("lock_cleared", 5'h00, 32'd0);

    // Kick on the same edge as the expiring tick
    wr(5'h04, 32'd1);
    wr(5'h00, 32'd1);
    for (int i = 0; i < 2 * TD - 1; i++) step(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
    wr(5'h08, KICK_KEY);
    rd_expect("kick_edge_count", 5'h0C, 32'd1);
    step(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
    check_val("kick_edge_nofire", {31'd0, soft_rst_en}, 32'd0);

    // LOAD=0: FIRE at first tick, output one cycle later
    do_reset();
    wr(5'h00, 32'd1);
    k = 0;
    while (soft_rst_en !== 1'b1 && k < 50) begin
      step(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
      k++;
    end
    check_val("load0_latency", k, TD + 1);

`ifdef WDG_PRE_IRQ_EN
    // Pre-timeout warning
    do_reset();
    wr(5'h04, 32'd10);
    wr(5'h10, 32'd2);
    wr(5'h00, 32'd1);
    k = 0;
    while (irq !== 1'b1 && k < 100) begin
      step(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
      k++;
    end
    check_val("irq_rise", {31'd0, irq}, 32'd1);
    rd_expect("irq_count", 5'h0C, 32'd2);
    wr(5'h08, KICK_KEY);
    check_val("irq_fall", {31'd0, irq}, 32'd0);
`else
    do_reset();
    wr(5'h10, 32'hA5A5_0003);
    rd_expect("warn_absent", 5'h10, 32'd0);
`endif

    // Randomized register traffic
    for (int ep = 0; ep < 12; ep++) begin
      int fire_cycles;
      do_reset();
      fire_cycles = 0;
      for (int c = 0; c < 400; c++) begin
        bit we, re, rst;
        logic [4:0] addr;
        logic [31:0] wd;
        int sel;
        rst = ($urandom_range(0, 299) != 0) && (fire_cycles < 10);
        we = ($urandom_range(0, 2) == 0);
        re = ($urandom_range(0, 1) == 0);
        sel = $urandom_range(0, 7);
        addr = {sel[2:0], 2'($urandom_range(0, 3))};
        case (sel)
          0: wd = {30'd0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0)};
          1: wd = 32'($urandom_range(0, 6));
          2: begin
            k = $urandom_range(0, 99);
            wd = (k < 60) ? KICK_KEY : (k < 62) ? RST_KEY : 32'($urandom);
          end
          4: wd = 32'($urandom_range(0, 4));
          default: wd = 32'($urandom);
        endcase
        step(rst, we, re, addr, wd);
        fire_cycles = m_fired ? fire_cycles + 1 : 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $finish;
  end
endmodule
